// File: rtl/fetch_branch_predictor.sv
// fetch_branch_predictor: fetch PC generator with a 1-bit BHT and tagged BTB, enabled by BRANCH_PREDICT_EN.
// Without BRANCH_PREDICT_EN there is no table storage and fetch always predicts fall-through.
module fetch_branch_predictor #(
  parameter int          IDX_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall_fetch,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_decode,
  output logic        o_pred_taken_decode,
  output logic [31:0] o_pred_target_decode,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_flush_decode,
  output logic        o_flush_execute,
  output logic [31:0] o_branch_cnt,
  output logic [31:0] o_mispredict_cnt
);
  logic [31:0] pc_q, pc_d, pcd_q, pcd_d, ptg_q, ptg_d, bcnt_q, mcnt_q;
  logic [31:0] pc_inc, pred_nxt, redir;
  logic        ptk_q, ptk_d, pred_tk, mp, ex_br;
  assign pc_inc = pc_q + 32'd4;
  assign ex_br  = i_ex_valid && i_ex_is_branch;
  assign redir  = (i_ex_is_branch && i_ex_taken) ? i_ex_target : i_ex_pc + 32'd4;
`ifdef BRANCH_PREDICT_EN
  localparam int N  = 1 << IDX_BITS;
  localparam int TW = 30 - IDX_BITS;
  logic [N-1:0]        vld_q, hist_q;
  logic [TW-1:0]       tag_q [N];
  logic [31:0]         tgt_q [N];
  logic [IDX_BITS-1:0] lidx, widx;
  assign lidx     = pc_q[IDX_BITS+1:2];
  assign widx     = i_ex_pc[IDX_BITS+1:2];
  assign pred_tk  = vld_q[lidx] && (tag_q[lidx] == pc_q[31:IDX_BITS+2]) && hist_q[lidx];
  assign pred_nxt = pred_tk ? tgt_q[lidx] : pc_inc;
  assign mp = i_ex_valid && (i_ex_is_branch
              ? (i_ex_taken != i_ex_pred_taken) || (i_ex_taken && i_ex_target != i_ex_pred_target)
              : i_ex_pred_taken);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) vld_q <= '0;
    else if (ex_br) vld_q[widx] <= 1'b1;
    else if (i_ex_valid && i_ex_pred_taken) vld_q[widx] <= 1'b0;
  // Payload needs no reset: an entry is only trusted once its valid bit is set.
  always_ff @(posedge i_clk)
    if (ex_br) begin
      tag_q[widx]  <= i_ex_pc[31:IDX_BITS+2];
      hist_q[widx] <= i_ex_taken;
      if (i_ex_taken) tgt_q[widx] <= i_ex_target;
    end
`else
  logic unused_pred;
  assign unused_pred = ^{i_ex_pred_taken, i_ex_pred_target};
  assign pred_tk  = 1'b0;
  assign pred_nxt = pc_inc;
  assign mp       = ex_br && i_ex_taken;
`endif
  always_comb begin
    pc_d  = mp ? redir : i_stall_fetch ? pc_q : pred_nxt;
    pcd_d = mp ? 32'd0 : i_stall_fetch ? pcd_q : pc_q;
    ptk_d = mp ? 1'b0 : i_stall_fetch ? ptk_q : pred_tk;
    ptg_d = mp ? 32'd0 : i_stall_fetch ? ptg_q : pred_nxt;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      pc_q   <= RESET_PC;
      pcd_q  <= '0;
      ptk_q  <= 1'b0;
      ptg_q  <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pcd_q  <= pcd_d;
      ptk_q  <= ptk_d;
      ptg_q  <= ptg_d;
      bcnt_q <= bcnt_q + {31'd0, ex_br && !(&bcnt_q)};
      mcnt_q <= mcnt_q + {31'd0, mp && !(&mcnt_q)};
    end
  assign o_pc                 = pc_q;
  assign o_pc_decode          = pcd_q;
  assign o_pred_taken_decode  = ptk_q;
  assign o_pred_target_decode = ptg_q;
  assign o_flush_decode       = mp && !i_reset;
  assign o_flush_execute      = mp && !i_reset;
  assign o_branch_cnt         = bcnt_q;
  assign o_mispredict_cnt     = mcnt_q;
endmodule

// File: doc/fetch_branch_predictor.md
# fetch_branch_predictor

Fetch-stage PC generator with a 1-bit branch history table (BHT) and tagged branch target buffer (BTB). It drives the PC into the instruction memory, predicts the next PC each cycle, and resolves predictions against branch outcomes reported by the execute stage. On a mispredict it redirects fetch and flushes the decode and execute stages. It sits directly upstream of the instruction memory; its PC and prediction outputs are registered alongside the fetched instruction.

## Interface
Parameters:
- `IDX_BITS`, 6: BHT/BTB index width; entries = 2**IDX_BITS, indexed by `pc[IDX_BITS+1:2]`.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

Ports:
- `i_clk` input 1: clock, rising edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_stall_fetch` input 1: hazard unit hold; PC and decode-side registers keep their values.
- `o_pc` output 32: current fetch PC, wired to instruction memory `i_pc`.
- `o_pc_decode` output 32: PC of the instruction now in decode.
- `o_pred_taken_decode` output 1: prediction made for `o_pc_decode`.
- `o_pred_target_decode` output 32: predicted target for `o_pc_decode`.
- `i_ex_valid` input 1: execute-stage slot holds a real instruction.
- `i_ex_is_branch` input 1: instruction is a conditional branch or JAL/JALR.
- `i_ex_pc` input 32: PC of the execute instruction.
- `i_ex_taken` input 1: actual outcome.
- `i_ex_target` input 32: actual target; meaningful only when taken.
- `i_ex_pred_taken` input 1: prediction carried down the pipe.
- `i_ex_pred_target` input 32: predicted target carried down the pipe.
- `o_flush_decode` output 1: combinational; clears the decode instruction (instruction memory `i_flush_decode`).
- `o_flush_execute` output 1: combinational; clears the decode→execute register.
- `o_branch_cnt` output 32: resolved-branch counter.
- `o_mispredict_cnt` output 32: mispredict counter.

## Operation
- Each table entry holds `valid`, `tag = pc[31:IDX_BITS+2]`, a 32-bit `target`, and a 1-bit `hist`.
- Lookup is combinational on `o_pc`. `hit = valid && tag match`. The prediction is taken when `hit && hist`. Predicted next PC is `target` if taken, else `o_pc + 4`.
- Mispredict (`mp`) is evaluated when `i_ex_valid`. It is asserted when any of these holds:
  - `i_ex_is_branch` and `i_ex_taken != i_ex_pred_taken`.
  - `i_ex_is_branch`, `i_ex_taken`, `i_ex_pred_taken`, and `i_ex_target != i_ex_pred_target`.
  - not `i_ex_is_branch` but `i_ex_pred_taken`.
- Redirect PC = `i_ex_taken ? i_ex_target : i_ex_pc + 4`; it is `i_ex_pc + 4` for the non-branch case.
- `o_flush_decode = o_flush_execute = mp`.
- Next `o_pc` priority: `mp` → redirect PC; else `i_stall_fetch` → hold; else predicted next PC.
- Decode-side registers (`o_pc_decode`, `o_pred_*_decode`) use the same priority:
  - `mp` → PC 0, pred 0, target 0.
  - stall → hold.
  - else capture the current `o_pc` and its prediction.
- Table update, on `i_ex_valid && i_ex_is_branch`: write the entry at `i_ex_pc` index with `valid=1`, tag, and `hist=i_ex_taken`. `target` is written only when taken.
- Non-branch predicted taken: clear the entry's `valid` bit.
- Updates happen regardless of `i_stall_fetch`.
- Counters: `o_branch_cnt` increments per resolved branch; `o_mispredict_cnt` increments per `mp`. Both saturate at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - `o_pc = RESET_PC`.
  - `o_pc_decode = 0`, `o_pred_taken_decode = 0`, `o_pred_target_decode = 0`.
  - counters = 0.
  - all `valid` bits = 0.
  - flushes are 0 while `i_reset` is high.
- Reset asserted mid-operation clears all state immediately, including any update in flight.
- Prediction has zero-cycle lookup latency. The redirected PC appears on `o_pc` one edge after `mp`; the fetch penalty is 2 cycles.
- A table write becomes visible to lookup on the following cycle. A same-cycle lookup of the entry being written returns the old contents.
- Index aliasing: a tag mismatch is a miss, and the prediction is not-taken.
- PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Configuration
- `BRANCH_PREDICT_EN` defined: BHT/BTB instantiated as above.
- Undefined: no table storage; prediction is always not-taken with next PC = `o_pc + 4`. `mp` then reduces to `i_ex_valid && i_ex_is_branch && i_ex_taken`. Counters and the rest of the ports are unchanged.

## Test plan
- Reset sequence: hold `i_reset`=1, release; no other stimulus.
  - During reset: `o_pc`=RESET_PC.
  - After release: `o_pc` steps 0, 4, 8, … each cycle; all flushes 0.
- Stall: `i_stall_fetch`=1 for 3 cycles at `o_pc`=0x10 → `o_pc` stays 0x10 for those 3 cycles and `o_pc_decode` holds; the sequence resumes at 0x14.
- Cold branch:
  - Stimulus: EX reports pc=0x20, taken, target=0x80, pred_taken=0.
  - Same cycle: `o_flush_decode`=`o_flush_execute`=1.
  - Next cycle: `o_pc`=0x80; `o_mispredict_cnt`=1.
- Learned branch: `o_pc` reaches 0x20 again after the cold-branch update → predicted taken, next `o_pc`=0x80. If EX then confirms taken with target 0x80, there is no flush.
- Flip to not-taken: EX reports pc=0x20, not taken, pred_taken=1 → flush, `o_pc`=0x24. On the next visit to 0x20 the prediction is not-taken.
- Same-cycle EX update and lookup of index 8:
  - Stimulus: EX writes index 8 from pc=0x20; fetch looks up pc=0x120 at the same index in the same cycle.
  - Same cycle: old contents are used.
  - Next cycle: a lookup of 0x120 misses on tag.
  - With the macro undefined, every taken branch flushes.
